// File: rtl/addr_xlate_stage.sv
// Registered fixed-mapping MIPS address translation for NUM_CH independent request channels.
// Each channel yields paddr, a cacheability attribute and address-error flags one cycle later.
module addr_xlate_stage #(
    parameter int unsigned NUM_CH    = 2,
    parameter logic        KU_CACHED = 1'b1,
    parameter logic [31:0] UC_BASE   = 32'h1F00_0000,
    parameter logic [31:0] UC_MASK   = 32'hFF00_0000
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [NUM_CH-1:0]     req_valid,
    input  logic [32*NUM_CH-1:0]  req_vaddr,
    input  logic [2*NUM_CH-1:0]   req_size,
    input  logic [NUM_CH-1:0]     req_write,
    input  logic [NUM_CH-1:0]     stall,
    input  logic                  flush,
    input  logic                  user_mode,
    input  logic [2:0]            k0,
    output logic [NUM_CH-1:0]     out_valid,
    output logic [32*NUM_CH-1:0]  out_paddr,
    output logic [NUM_CH-1:0]     out_cached,
    output logic [NUM_CH-1:0]     out_adel,
    output logic [NUM_CH-1:0]     out_ades,
    output logic [32*NUM_CH-1:0]  out_badvaddr
);

    localparam logic [31:0] UcMatch = UC_BASE & UC_MASK;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [31:0] va;
        logic [1:0]  size;
        logic        wr;

        logic [31:0] paddr_d;
        logic        cached_d;
        logic        misaligned;
        logic        priv_err;
        logic        err;
        logic        adel_d;
        logic        ades_d;
        logic        load;

        logic        valid_q;
        logic [31:0] paddr_q;
        logic        cached_q;
        logic        adel_q;
        logic        ades_q;
        logic [31:0] badvaddr_q;

        assign va   = req_vaddr[32*i +: 32];
        assign size = req_size[2*i +: 2];
        assign wr   = req_write[i];

        // Segment decode: kseg0/kseg1 are unmapped windows onto the low 512 MiB.
        always_comb begin
            paddr_d  = va;
            cached_d = KU_CACHED;
            case (va[31:29])
                3'b100: begin
                    paddr_d  = {3'b000, va[28:0]};
                    cached_d = (k0 == 3'd3);
                end
                3'b101: begin
                    paddr_d  = {3'b000, va[28:0]};
                    cached_d = 1'b0;
                end
                default: begin
                    paddr_d  = va;
                    cached_d = KU_CACHED;
                end
            endcase
            if ((paddr_d & UC_MASK) == UcMatch) begin
                cached_d = 1'b0;
            end
            if (err) begin
                cached_d = 1'b0;
            end
        end

        always_comb begin
            misaligned = 1'b0;
            case (size)
                2'd0:    misaligned = 1'b0;
                2'd1:    misaligned = va[0];
                default: misaligned = |va[1:0];
            endcase
        end

        assign priv_err = user_mode & va[31];
        assign err      = misaligned | priv_err;
        assign adel_d   = req_valid[i] & err & ~wr;
        assign ades_d   = req_valid[i] & err & wr;

        // A held result may only be replaced once it is consumed or was never valid.
        assign load = ~stall[i] | ~valid_q;

        always_ff @(posedge aclk) begin
            if (!aresetn) begin
                valid_q    <= 1'b0;
                paddr_q    <= '0;
                cached_q   <= 1'b0;
                adel_q     <= 1'b0;
                ades_q     <= 1'b0;
                badvaddr_q <= '0;
            end else if (flush) begin
                valid_q <= 1'b0;
                adel_q  <= 1'b0;
                ades_q  <= 1'b0;
            end else if (load) begin
                valid_q    <= req_valid[i];
                paddr_q    <= paddr_d;
                cached_q   <= cached_d;
                adel_q     <= adel_d;
                ades_q     <= ades_d;
                badvaddr_q <= va;
            end
        end

        assign out_valid[i]             = valid_q;
        assign out_paddr[32*i +: 32]    = paddr_q;
        assign out_cached[i]            = cached_q;
        assign out_adel[i]              = adel_q;
        assign out_ades[i]              = ades_q;
        assign out_badvaddr[32*i +: 32] = badvaddr_q;
    end

endmodule
